// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on accept, then one PC-2 subkey per cycle on a valid/ready
// stream. Optional key parity check is enabled by the DES_KS_PARITY_CHECK_EN macro.
module des_key_schedule #(
  parameter int unsigned ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h8103,
  parameter bit          RAW_CD     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [0:47] k_out,
  output logic [3:0]  k_round,
  output logic        k_last,
  output logic        k_valid,
  input  logic        k_ready,
`ifdef DES_KS_PARITY_CHECK_EN
  output logic        parity_err,
`endif
  output logic        busy
);

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    logic [5:0]  idx;
    for (int i = 0; i < 56; i++) begin
      idx  = 6'(Pc1Tbl[i] - 1);
      r[i] = k[idx];
    end
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    logic [5:0]  idx;
    for (int i = 0; i < 48; i++) begin
      idx  = 6'(Pc2Tbl[i] - 1);
      r[i] = cd[idx];
    end
    return r;
  endfunction

  // Index 0 is the MSB, so a left rotate moves bits toward index 0.
  function automatic logic [0:55] rotl(input logic [0:55] cd, input logic one);
    logic [0:27] c, d;
    c = cd[0:27];
    d = cd[28:55];
    if (one) return {c[1:27], c[0], d[1:27], d[0]};
    return {c[2:27], c[0:1], d[2:27], d[0:1]};
  endfunction

  function automatic logic [0:55] rotr(input logic [0:55] cd, input logic one);
    logic [0:27] c, d;
    c = cd[0:27];
    d = cd[28:55];
    if (one) return {c[27], c[0:26], d[27], d[0:26]};
    return {c[26:27], c[0:25], d[26:27], d[0:25]};
  endfunction

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [0:55] cd_q, cd_d, cd_next, key_cd;
  logic [0:47] kout_q, kout_d;
  logic [3:0]  round_q, round_d, round_inc;
  logic        dec_q, dec_d, dec_ok, accept, last;

  assign key_cd    = RAW_CD ? key_in[0:55] : pc1(key_in);
  assign dec_ok    = decrypt && (ROUNDS == 32'd16);
  assign accept    = key_valid && key_ready;
  assign last      = dec_q ? (round_q == 4'd0) : (round_q == LastRound);
  assign round_inc = round_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    kout_d  = kout_q;
    round_d = round_q;
    dec_d   = dec_q;
    cd_next = cd_q;
    unique case (state_q)
      StIdle: begin
        if (key_valid) begin
          state_d = StRun;
          dec_d   = dec_ok;
          // Decrypt starts from C0D0 unrotated: the 16 shifts sum to 28, so C16D16 == C0D0.
          if (dec_ok) begin
            cd_next = key_cd;
            round_d = 4'd15;
          end else begin
            cd_next = rotl(key_cd, SHIFT_MASK[0]);
            round_d = 4'd0;
          end
          cd_d   = cd_next;
          kout_d = pc2(cd_next);
        end
      end
      StRun: begin
        if (k_ready) begin
          if (last) begin
            state_d = StIdle;
          end else begin
            if (dec_q) begin
              cd_next = rotr(cd_q, SHIFT_MASK[round_q]);
              round_d = round_q - 4'd1;
            end else begin
              cd_next = rotl(cd_q, SHIFT_MASK[round_inc]);
              round_d = round_inc;
            end
            cd_d   = cd_next;
            kout_d = pc2(cd_next);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      kout_q  <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      kout_q  <= kout_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign key_ready = (state_q == StIdle);
  assign k_valid   = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign k_out     = kout_q;
  assign k_round   = round_q;
  assign k_last    = k_valid && last;

`ifdef DES_KS_PARITY_CHECK_EN
  logic parity_q, parity_d, key_par_bad;

  // FIPS keys carry odd parity per byte; any even byte flags the key.
  always_comb begin
    key_par_bad = 1'b0;
    for (int b = 0; b < 8; b++) key_par_bad = key_par_bad | ~^key_in[8*b +: 8];
  end

  assign parity_d = accept ? (key_par_bad && !RAW_CD) : parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign parity_err = parity_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: FIPS example key, encrypt/decrypt, stall, reset, ROUNDS=4.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:63] key_in;
  logic        decrypt, key_valid, k_ready;
  logic        key_ready, k_last, k_valid, busy;
  logic [0:47] k_out;
  logic [3:0]  k_round;
  logic        key_valid4;
  logic        key_ready4, k_last4, k_valid4, busy4;
  logic [0:47] k_out4;
  logic [3:0]  k_round4;
`ifdef DES_KS_PARITY_CHECK_EN
  logic        parity_err, parity_err4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] kexp [16];

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(16)) u_dut (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .key_valid(key_valid),
    .key_ready(key_ready), .k_out(k_out), .k_round(k_round), .k_last(k_last),
    .k_valid(k_valid), .k_ready(k_ready),
`ifdef DES_KS_PARITY_CHECK_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  des_key_schedule #(.ROUNDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .key_valid(key_valid4),
    .key_ready(key_ready4), .k_out(k_out4), .k_round(k_round4), .k_last(k_last4),
    .k_valid(k_valid4), .k_ready(1'b1),
`ifdef DES_KS_PARITY_CHECK_EN
    .parity_err(parity_err4),
`endif
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after the accepting edge; leaves just after the final handshake.
  task automatic run_check(input bit dec, input int stall_at, input string tag);
    int r;
    for (int s = 0; s < 16; s++) begin
      r = dec ? 15 - s : s;
      chk($sformatf("%s s%0d k_valid", tag, s), 64'(k_valid), 64'd1);
      chk($sformatf("%s s%0d k_out", tag, s), 64'(k_out), 64'(kexp[r]));
      chk($sformatf("%s s%0d k_round", tag, s), 64'(k_round), 64'(r));
      chk($sformatf("%s s%0d k_last", tag, s), 64'(k_last), 64'(s == 15));
      if (s == stall_at) begin
        k_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          step();
          chk($sformatf("%s stall%0d k_out", tag, c), 64'(k_out), 64'(kexp[r]));
          chk($sformatf("%s stall%0d k_round", tag, c), 64'(k_round), 64'(r));
          chk($sformatf("%s stall%0d k_last", tag, c), 64'(k_last), 64'd0);
          chk($sformatf("%s stall%0d k_valid", tag, c), 64'(k_valid), 64'd1);
        end
        k_ready = 1'b1;
      end
      step();
    end
    chk({tag, " end k_valid"}, 64'(k_valid), 64'd0);
    chk({tag, " end busy"}, 64'(busy), 64'd0);
    chk({tag, " end key_ready"}, 64'(key_ready), 64'd1);
  endtask

  task automatic accept(input logic [63:0] key, input bit dec);
    key_in    = key;
    decrypt   = dec;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kexp = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; k_ready = 1'b1;
    key_valid4 = 1'b0;
    repeat (2) step();
    chk("rst k_valid", 64'(k_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst k_out", 64'(k_out), 64'd0);
    chk("rst k_round", 64'(k_round), 64'd0);
    chk("rst k_last", 64'(k_last), 64'd0);
    rst = 1'b0;
    step();
    chk("rst key_ready", 64'(key_ready), 64'd1);

    // Encrypt with the FIPS example key, no stall.
    accept(64'h133457799BBCDFF1, 1'b0);
    chk("enc busy", 64'(busy), 64'd1);
    chk("enc key_ready low", 64'(key_ready), 64'd0);
    run_check(1'b0, -1, "enc");
`ifdef DES_KS_PARITY_CHECK_EN
    chk("enc parity_err", 64'(parity_err), 64'd0);
`endif

    // Decrypt order.
    accept(64'h133457799BBCDFF1, 1'b1);
    run_check(1'b1, -1, "dec");

    // Backpressure at round 5.
    accept(64'h133457799BBCDFF1, 1'b0);
    run_check(1'b0, 5, "stall");

    // key_valid held through the schedule: second key (decrypt) waits for the idle cycle.
    key_in = 64'h133457799BBCDFF1; decrypt = 1'b0; key_valid = 1'b1;
    step();
    decrypt = 1'b1;
    run_check(1'b0, -1, "hold");
    step();
    key_valid = 1'b0;
    run_check(1'b1, -1, "hold2");

    // Asynchronous reset mid-schedule at round 7.
    accept(64'h133457799BBCDFF1, 1'b0);
    repeat (7) step();
    chk("pre-rst k_round", 64'(k_round), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst k_valid", 64'(k_valid), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post-rst k_valid", 64'(k_valid), 64'd0);
    accept(64'h133457799BBCDFF1, 1'b0);
    run_check(1'b0, -1, "post-rst");

    // ROUNDS=4 instance ignores decrypt.
    key_in = 64'h133457799BBCDFF1; decrypt = 1'b1; key_valid4 = 1'b1;
    step();
    key_valid4 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("r4 s%0d k_valid", s), 64'(k_valid4), 64'd1);
      chk($sformatf("r4 s%0d k_round", s), 64'(k_round4), 64'(s));
      chk($sformatf("r4 s%0d k_out", s), 64'(k_out4), 64'(kexp[s]));
      chk($sformatf("r4 s%0d k_last", s), 64'(k_last4), 64'(s == 3));
      step();
    end
    chk("r4 end k_valid", 64'(k_valid4), 64'd0);
    chk("r4 end key_ready", 64'(key_ready4), 64'd1);
`ifdef DES_KS_PARITY_CHECK_EN
    key_in = 64'h0000000000000000; decrypt = 1'b0; key_valid4 = 1'b1;
    step();
    key_valid4 = 1'b0;
    chk("par zero key", 64'(parity_err4), 64'd1);
    repeat (4) step();
    chk("par hold", 64'(parity_err4), 64'd1);
    key_in = 64'h0101010101010101; key_valid4 = 1'b1;
    step();
    key_valid4 = 1'b0;
    chk("par odd key", 64'(parity_err4), 64'd0);
    repeat (4) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
